soft_error_monitor: RTL and testbench

Counts soft-error events from three sources: data-corruption checksum mismatches, unknown TTC broadcast commands and DDR3 overflows. Each count is compared against a software-programmed threshold, and the block raises sticky error and warning flags. It sits directly upstream of the status register block and drives its count inputs (`cs_mismatch_count`, `unknown_cmd_count`, `ddr3_overflow_count`) and its flags (`error_data_corrupt`, `error_unknown_ttc`, `ddr3_overflow_warning`). The thresholds are passed through from IPbus control registers.

---
 rtl/soft_error_monitor_pkg.sv | 29 ++
 rtl/soft_error_monitor_channel.sv | 143 ++++++++++++++
 rtl/soft_error_monitor.sv | 131 +++++++++++++
 tb/tb_soft_error_monitor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soft_error_monitor_pkg.sv
// -----------------------------------------------------------------------------
// soft_error_monitor_pkg
//
// Shared definitions for the soft-error monitor:
//   soft_err_state_t  - per-channel state (OK / WARN / ERROR)
//   DEF_CNT_WIDTH     - default width of every counter and threshold
//   DEF_WARN_SHIFT    - default right shift that derives the warning level
//                       from a channel threshold
//   warn_level()      - helper that computes the warning level
// -----------------------------------------------------------------------------
package soft_error_monitor_pkg;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_ERROR = 2'd2
  } soft_err_state_t;

  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_WARN_SHIFT = 1;

  // Warning level used by a channel: the threshold scaled down by
  // 2^shift. Kept at full 32-bit width; callers truncate to their width.
  function automatic logic [31:0] warn_level(input logic [31:0] thres,
                                              input int          shift);
    warn_level = thres >> shift;
  endfunction

endpackage

// File: rtl/soft_error_monitor_channel.sv
// -----------------------------------------------------------------------------
// soft_error_channel
//
// One soft-error channel: a saturating event counter plus a three-state
// severity FSM (OK -> WARN -> ERROR) compared against a programmable
// threshold.
//
// Ports:
//   clk, reset_n    - clock, asynchronous active-low reset
//   count_en        - events are counted only while high
//   clear           - synchronous clear of count and state (wins over evt)
//   evt             - one-cycle pulse per event
//   thres           - threshold; 0 disables all state transitions
//   count           - registered event count (saturating)
//   warn            - high while the channel is in WARN
//   err             - high while the channel is in ERROR (sticky)
//   hard_err_next   - next-cycle ERROR indication, qualified by HARD_ERROR,
//                     so the parent can register a summary error flag with
//                     the same latency as err
//   state           - current FSM state (debug visibility)
//
// Handshake: there is no flow control; evt, clear and count_en are sampled
// on every rising clk edge and take effect on the outputs after that edge.
// -----------------------------------------------------------------------------
module soft_error_channel
  import soft_error_monitor_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int WARN_SHIFT = DEF_WARN_SHIFT,
  parameter bit HARD_ERROR = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 count_en,
  input  logic                 clear,
  input  logic                 evt,
  input  logic [CNT_WIDTH-1:0] thres,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 warn,
  output logic                 err,
  output logic                 hard_err_next,
  output soft_err_state_t      state
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] next_count;
  logic [CNT_WIDTH-1:0] warn_thres;
  logic                 saturated;
  logic                 thres_on;
  logic                 hit_warn;
  logic                 hit_err;
  soft_err_state_t      state_q;
  soft_err_state_t      state_d;

  // ---------------------------------------------------------------------------
  // Counter: increments once per qualified event and holds at all-ones.
  // ---------------------------------------------------------------------------
  assign saturated = &count_q;

  always_comb begin
    next_count = count_q;
    if (clear) begin
      next_count = '0;
    end else if (evt && count_en && !saturated) begin
      next_count = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= next_count;
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold comparisons. They run every cycle against next_count so that a
  // threshold lowered under the current count trips on the next edge even
  // without a new event.
  // ---------------------------------------------------------------------------
  assign warn_thres = thres >> WARN_SHIFT;
  assign thres_on   = (thres != '0);
  assign hit_err    = thres_on && (next_count >= thres);
  assign hit_warn   = thres_on && (warn_thres != '0) && (next_count >= warn_thres);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OK;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. ERROR has priority over WARN; both are left only
  // by clear (or reset).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_OK;
    end else begin
      case (state_q)
        ST_OK: begin
          if (hit_err) begin
            state_d = ST_ERROR;
          end else if (hit_warn) begin
            state_d = ST_WARN;
          end
        end
        ST_WARN: begin
          if (hit_err) begin
            state_d = ST_ERROR;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_OK;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. warn/err decode the state register directly, so they
  // change only at clock edges.
  // ---------------------------------------------------------------------------
  always_comb begin
    warn          = (state_q == ST_WARN);
    err           = (state_q == ST_ERROR);
    hard_err_next = HARD_ERROR && (state_d == ST_ERROR);
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: rtl/soft_error_monitor.sv
// -----------------------------------------------------------------------------
// soft_error_monitor
//
// Counts soft-error events from three sources and raises sticky flags when
// the counts reach software-programmed thresholds.
//
//   channel 0 : checksum mismatches      -> error_data_corrupt (hard error)
//   channel 1 : unknown TTC commands     -> error_unknown_ttc  (hard error)
//   channel 2 : DDR3 overflows           -> ddr3_overflow_warning (its ERROR
//                                           state is only a warning)
//
// Ports:
//   clk, reset_n                - clock, asynchronous active-low reset
//   count_en                    - run active; events ignored while low
//   clear                       - sync pulse, zeroes counts and flags
//   cs_mismatch, unknown_ttc,
//   ddr3_overflow               - one-cycle event pulses
//   thres_*                     - per-channel thresholds (0 = flags disabled)
//   *_count                     - registered counts
//   error_*, ddr3_overflow_warning - sticky ERROR flags
//   warn_*                      - high while channel is in WARN
//   any_error                   - registered OR of the two hard errors
//   state_dbg                   - {ch2, ch1, ch0} FSM states for debug
//
// All inputs are sampled on the rising edge of clk; every output is
// registered and reflects the inputs of the previous cycle.
// -----------------------------------------------------------------------------
module soft_error_monitor
  import soft_error_monitor_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int WARN_SHIFT = DEF_WARN_SHIFT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 count_en,
  input  logic                 clear,
  input  logic                 cs_mismatch,
  input  logic                 unknown_ttc,
  input  logic                 ddr3_overflow,
  input  logic [CNT_WIDTH-1:0] thres_data_corrupt,
  input  logic [CNT_WIDTH-1:0] thres_unknown_ttc,
  input  logic [CNT_WIDTH-1:0] thres_ddr3_overflow,
  output logic [CNT_WIDTH-1:0] cs_mismatch_count,
  output logic [CNT_WIDTH-1:0] unknown_cmd_count,
  output logic [CNT_WIDTH-1:0] ddr3_overflow_count,
  output logic                 error_data_corrupt,
  output logic                 error_unknown_ttc,
  output logic                 ddr3_overflow_warning,
  output logic                 warn_data_corrupt,
  output logic                 warn_unknown_ttc,
  output logic                 warn_ddr3_overflow,
  output logic                 any_error,
  output logic [5:0]           state_dbg
);

  logic            hard_next_dc;
  logic            hard_next_ut;
  logic            hard_next_dd;
  soft_err_state_t st_dc;
  soft_err_state_t st_ut;
  soft_err_state_t st_dd;

  soft_error_channel #(
    .CNT_WIDTH  (CNT_WIDTH),
    .WARN_SHIFT (WARN_SHIFT),
    .HARD_ERROR (1'b1)
  ) u_data_corrupt (
    .clk           (clk),
    .reset_n       (reset_n),
    .count_en      (count_en),
    .clear         (clear),
    .evt           (cs_mismatch),
    .thres         (thres_data_corrupt),
    .count         (cs_mismatch_count),
    .warn          (warn_data_corrupt),
    .err           (error_data_corrupt),
    .hard_err_next (hard_next_dc),
    .state         (st_dc)
  );

  soft_error_channel #(
    .CNT_WIDTH  (CNT_WIDTH),
    .WARN_SHIFT (WARN_SHIFT),
    .HARD_ERROR (1'b1)
  ) u_unknown_ttc (
    .clk           (clk),
    .reset_n       (reset_n),
    .count_en      (count_en),
    .clear         (clear),
    .evt           (unknown_ttc),
    .thres         (thres_unknown_ttc),
    .count         (unknown_cmd_count),
    .warn          (warn_unknown_ttc),
    .err           (error_unknown_ttc),
    .hard_err_next (hard_next_ut),
    .state         (st_ut)
  );

  // The DDR3 channel's ERROR is a warning only, so it never feeds any_error.
  soft_error_channel #(
    .CNT_WIDTH  (CNT_WIDTH),
    .WARN_SHIFT (WARN_SHIFT),
    .HARD_ERROR (1'b0)
  ) u_ddr3_overflow (
    .clk           (clk),
    .reset_n       (reset_n),
    .count_en      (count_en),
    .clear         (clear),
    .evt           (ddr3_overflow),
    .thres         (thres_ddr3_overflow),
    .count         (ddr3_overflow_count),
    .warn          (warn_ddr3_overflow),
    .err           (ddr3_overflow_warning),
    .hard_err_next (hard_next_dd),
    .state         (st_dd)
  );

  // Registered from the channels' next-state so any_error moves on the same
  // edge as the error flags themselves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_error <= 1'b0;
    end else begin
      any_error <= hard_next_dc | hard_next_ut | hard_next_dd;
    end
  end

  assign state_dbg = {st_dd, st_ut, st_dc};

endmodule

// File: tb/tb_soft_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_soft_error_monitor
//
// Two instances share all inputs: a full-width (32-bit) monitor and a 4-bit
// one used to reach counter saturation quickly. A behavioural model tracks
// counts and sticky flags per channel and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_soft_error_monitor;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        count_en = 1'b0;
  logic        clear = 1'b0;
  logic        cs = 1'b0;
  logic        ut = 1'b0;
  logic        dd = 1'b0;
  logic [31:0] th [3];

  logic [31:0] cnt_m  [3];
  logic        flag_m [3];
  logic        warn_m [3];
  logic        any_m;
  logic [5:0]  dbg_m;

  logic [3:0]  cnt_s  [3];
  logic        flag_s [3];
  logic        warn_s [3];
  logic        any_s;
  logic [5:0]  dbg_s;

  soft_error_monitor #(.CNT_WIDTH(32), .WARN_SHIFT(1)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .count_en              (count_en),
    .clear                 (clear),
    .cs_mismatch           (cs),
    .unknown_ttc           (ut),
    .ddr3_overflow         (dd),
    .thres_data_corrupt    (th[0]),
    .thres_unknown_ttc     (th[1]),
    .thres_ddr3_overflow   (th[2]),
    .cs_mismatch_count     (cnt_m[0]),
    .unknown_cmd_count     (cnt_m[1]),
    .ddr3_overflow_count   (cnt_m[2]),
    .error_data_corrupt    (flag_m[0]),
    .error_unknown_ttc     (flag_m[1]),
    .ddr3_overflow_warning (flag_m[2]),
    .warn_data_corrupt     (warn_m[0]),
    .warn_unknown_ttc      (warn_m[1]),
    .warn_ddr3_overflow    (warn_m[2]),
    .any_error             (any_m),
    .state_dbg             (dbg_m)
  );

  soft_error_monitor #(.CNT_WIDTH(4), .WARN_SHIFT(1)) dut_small (
    .clk                   (clk),
    .reset_n               (reset_n),
    .count_en              (count_en),
    .clear                 (clear),
    .cs_mismatch           (cs),
    .unknown_ttc           (ut),
    .ddr3_overflow         (dd),
    .thres_data_corrupt    (th[0][3:0]),
    .thres_unknown_ttc     (th[1][3:0]),
    .thres_ddr3_overflow   (th[2][3:0]),
    .cs_mismatch_count     (cnt_s[0]),
    .unknown_cmd_count     (cnt_s[1]),
    .ddr3_overflow_count   (cnt_s[2]),
    .error_data_corrupt    (flag_s[0]),
    .error_unknown_ttc     (flag_s[1]),
    .ddr3_overflow_warning (flag_s[2]),
    .warn_data_corrupt     (warn_s[0]),
    .warn_unknown_ttc      (warn_s[1]),
    .warn_ddr3_overflow    (warn_s[2]),
    .any_error             (any_s),
    .state_dbg             (dbg_s)
  );

  // ---------------------------------------------------------------------------
  // Reference model: index 0 = 32-bit instance, 1 = 4-bit instance
  // ---------------------------------------------------------------------------
  longint m_cnt  [2][3];
  bit     m_warn [2][3];
  bit     m_err  [2][3];
  bit     m_any  [2];

  int n_vec = 0;
  int n_bad = 0;

  function automatic longint max_of(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        m_cnt[d][c]  = 0;
        m_warn[d][c] = 0;
        m_err[d][c]  = 0;
      end
      m_any[d] = 0;
    end
  endtask

  // Apply one clock edge worth of the rules to the model.
  task automatic model_step();
    bit     ev [3];
    longint t;
    longint nc;
    ev[0] = cs;
    ev[1] = ut;
    ev[2] = dd;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        t  = longint'(th[c]) & max_of(d);
        nc = m_cnt[d][c];
        if (clear) begin
          nc = 0;
          m_warn[d][c] = 0;
          m_err[d][c]  = 0;
        end else begin
          if (ev[c] && count_en && nc < max_of(d)) nc = nc + 1;
          if (t != 0 && nc >= t) begin
            m_err[d][c]  = 1;
            m_warn[d][c] = 0;
          end else if (!m_err[d][c] && t != 0 && (t / 2) != 0 && nc >= t / 2) begin
            m_warn[d][c] = 1;
          end
        end
        m_cnt[d][c] = nc;
      end
      m_any[d] = m_err[d][0] | m_err[d][1];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("w32 ch%0d count", c), {32'd0, cnt_m[c]}, m_cnt[0][c]);
      check($sformatf("w32 ch%0d warn", c), {63'd0, warn_m[c]}, {63'd0, m_warn[0][c]});
      check($sformatf("w32 ch%0d err", c), {63'd0, flag_m[c]}, {63'd0, m_err[0][c]});
      check($sformatf("w4 ch%0d count", c), {60'd0, cnt_s[c]}, m_cnt[1][c]);
      check($sformatf("w4 ch%0d warn", c), {63'd0, warn_s[c]}, {63'd0, m_warn[1][c]});
      check($sformatf("w4 ch%0d err", c), {63'd0, flag_s[c]}, {63'd0, m_err[1][c]});
    end
    check("w32 any_error", {63'd0, any_m}, {63'd0, m_any[0]});
    check("w4 any_error", {63'd0, any_s}, {63'd0, m_any[1]});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change only at the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse(input int c);
    cs = (c == 0);
    ut = (c == 1);
    dd = (c == 2);
    cycle();
    cs = 0;
    ut = 0;
    dd = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    cycle();
    clear = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    th[0] = 0;
    th[1] = 0;
    th[2] = 0;
    model_reset();

    // Reset state
    @(negedge clk);
    check_all();
    #2 reset_n = 1;
    count_en = 1;

    // Basic trip: threshold 4, warn at 2, error at 4
    th[0] = 4;
    for (int i = 1; i <= 4; i++) begin
      pulse(0);
      if (i == 1) check("trip warn after 1", {63'd0, warn_m[0]}, 64'd0);
      if (i == 2) check("trip warn after 2", {63'd0, warn_m[0]}, 64'd1);
      if (i == 3) check("trip err after 3", {63'd0, flag_m[0]}, 64'd0);
      cycle();
    end
    check("trip count", {32'd0, cnt_m[0]}, 64'd4);
    check("trip err", {63'd0, flag_m[0]}, 64'd1);
    check("trip any", {63'd0, any_m}, 64'd1);
    check("trip warn cleared", {63'd0, warn_m[0]}, 64'd0);

    // Clear together with an event on a channel holding 7
    do_clear();
    th[0] = 0;
    th[1] = 8;
    for (int i = 0; i < 7; i++) pulse(1);
    check("pre-clear count", {32'd0, cnt_m[1]}, 64'd7);
    check("pre-clear warn", {63'd0, warn_m[1]}, 64'd1);
    clear = 1;
    ut = 1;
    cycle();
    clear = 0;
    ut = 0;
    check("clear+evt count", {32'd0, cnt_m[1]}, 64'd0);
    check("clear+evt warn", {63'd0, warn_m[1]}, 64'd0);
    check("clear+evt err", {63'd0, flag_m[1]}, 64'd0);

    // Saturation on the 4-bit instance
    th[1] = 0;
    do_clear();
    cs = 1;
    for (int i = 0; i < 15; i++) cycle();
    check("sat reach 15", {60'd0, cnt_s[0]}, 64'd15);
    cycle();
    cycle();
    cs = 0;
    check("sat hold", {60'd0, cnt_s[0]}, 64'd15);
    check("sat wide count", {32'd0, cnt_m[0]}, 64'd17);

    // Disabled threshold, then late threshold write, then count_en low
    do_clear();
    th[2] = 0;
    dd = 1;
    for (int i = 0; i < 100; i++) cycle();
    dd = 0;
    check("disabled count", {32'd0, cnt_m[2]}, 64'd100);
    check("disabled warning", {63'd0, flag_m[2]}, 64'd0);
    th[2] = 50;
    cycle();
    check("late thres warning", {63'd0, flag_m[2]}, 64'd1);
    check("ddr not hard error", {63'd0, any_m}, 64'd0);
    th[2] = 0;
    cycle();
    check("thres 0 keeps flag", {63'd0, flag_m[2]}, 64'd1);
    count_en = 0;
    for (int i = 0; i < 3; i++) pulse(2);
    check("count_en low", {32'd0, cnt_m[2]}, 64'd100);
    count_en = 1;

    // Async reset mid-run while in ERROR with count 9
    do_clear();
    th[1] = 8;
    for (int i = 0; i < 9; i++) pulse(1);
    check("pre-reset count", {32'd0, cnt_m[1]}, 64'd9);
    check("pre-reset err", {63'd0, flag_m[1]}, 64'd1);
    #2 reset_n = 0;
    #1;
    model_reset();
    check("async rst count", {32'd0, cnt_m[1]}, 64'd0);
    check("async rst err", {63'd0, flag_m[1]}, 64'd0);
    check("async rst any", {63'd0, any_m}, 64'd0);
    check_all();
    #1 reset_n = 1;
    pulse(1);
    check("post-reset count", {32'd0, cnt_m[1]}, 64'd1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cs       = ($urandom_range(0, 3) == 0);
      ut       = ($urandom_range(0, 3) == 0);
      dd       = ($urandom_range(0, 2) == 0);
      clear    = ($urandom_range(0, 79) == 0);
      count_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        th[$urandom_range(0, 2)] = $urandom_range(0, 3) == 0 ? 32'd0 : 32'($urandom_range(1, 40));
      end
      cycle();
    end
    cs = 0;
    ut = 0;
    dd = 0;
    clear = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    n_bad++;
    $display("FAIL timeout: got no completion, expected finish before 500000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
